seg_scan_mux: RTL

Parametrised, time-multiplexed display scanner for the 7-segment output path. It holds N digit patterns in a double-buffered shadow register and steps through them one slot at a time. For each digit it drives one segment bus plus a one-hot digit-select bus, and it inserts a blanking interval at the start of every slot to suppress ghosting. It sits between the digit-encoding logic and the board pins, and supersedes the fixed 4:1 combinational selector.

---
 rtl/seg_scan_pkg.sv | 38 +++
 rtl/seg_scan_timer.sv | 57 +++++
 rtl/seg_scan_mux.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants, slot state type and select-vector helpers for the
// time-multiplexed 7-segment scanner (seg_scan_mux / seg_scan_timer).
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   localparam int DEF_N_DIGITS  = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_TICK_DIV  = 50000;
   localparam int DEF_BLANK_CYC = 16;

   // Widest select vector the helper can build; callers truncate to N_DIGITS.
   localparam int SEL_MAX_W = 32;

   // What the output stage drives during the current cycle of a slot.
   typedef enum logic {
      SLOT_BLANK = 1'b0,
      SLOT_SHOW  = 1'b1
   } slot_state_e;

   // One-hot select for digit idx, optionally inverted for active-low pins.
   function automatic logic [SEL_MAX_W-1:0] sel_onehot(input int unsigned idx,
                                                       input logic        active_low);
      logic [SEL_MAX_W-1:0] v;
      v = SEL_MAX_W'(1) << idx;
      if (active_low) begin
         v = ~v;
      end
      return v;
   endfunction

   // Select vector with every digit inactive.
   function automatic logic [SEL_MAX_W-1:0] sel_idle(input logic active_low);
      return active_low ? '1 : '0;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// -----------------------------------------------------------------------------
// seg_scan_timer
// Phase / digit counters for the display scanner. The counters hold the slot
// position that the *next* clock edge will present on the registered outputs,
// so the first edge after reset presents phase 0 of digit 0.
//
// Ports:
//   i_clk        - clock
//   i_rst        - asynchronous active-high reset
//   o_phase      - phase within the slot, 0..TICK_DIV-1
//   o_digit      - digit slot index, 0..N_DIGITS-1
//   o_blank      - o_phase < BLANK_CYC
//   o_frame_edge - the coming edge starts a new frame (phase 0, digit 0)
// -----------------------------------------------------------------------------
module seg_scan_timer
   import seg_scan_pkg::*;
#(
   parameter  int N_DIGITS  = DEF_N_DIGITS,
   parameter  int TICK_DIV  = DEF_TICK_DIV,
   parameter  int BLANK_CYC = DEF_BLANK_CYC,
   localparam int PH_W      = $clog2(TICK_DIV),
   localparam int DG_W      = $clog2(N_DIGITS)
)(
   input  logic            i_clk,
   input  logic            i_rst,
   output logic [PH_W-1:0] o_phase,
   output logic [DG_W-1:0] o_digit,
   output logic            o_blank,
   output logic            o_frame_edge
);

   logic [PH_W-1:0] r_phase;
   logic [DG_W-1:0] r_digit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_phase <= '0;
         r_digit <= '0;
      end else if (r_phase == PH_W'(TICK_DIV - 1)) begin
         r_phase <= '0;
         if (r_digit == DG_W'(N_DIGITS - 1)) begin
            r_digit <= '0;
         end else begin
            r_digit <= r_digit + 1'b1;
         end
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   // Signed compare keeps BLANK_CYC = 0 a plain "never blank" case.
   assign o_blank      = int'(r_phase) < BLANK_CYC;
   assign o_frame_edge = (r_phase == '0) && (r_digit == '0);
   assign o_phase      = r_phase;
   assign o_digit      = r_digit;

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed 7-segment scanner. Digit patterns are captured into a shadow
// register only on a frame edge, so a frame never mixes old and new data. Each
// digit slot starts with a blanking interval to suppress ghosting.
//
// Ports:
//   i_clk      - clock
//   i_rst      - asynchronous active-high reset
//   i_data     - digit k pattern at [k*DATA_W +: DATA_W]
//   i_digit_en - per-digit enable mask
//   i_load     - request capture of i_data / i_digit_en at the next frame edge
//   o_load_ack - one-cycle pulse in the first cycle of a frame using new data
//   o_data     - segment pattern for the current slot (BLANK_PAT when dark)
//   o_sel      - one-hot digit select, all inactive while blanked
//   o_digit    - current slot index
//   o_frame    - one-cycle pulse in the first cycle of each frame
// -----------------------------------------------------------------------------
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter  int                N_DIGITS       = DEF_N_DIGITS,
   parameter  int                DATA_W         = DEF_DATA_W,
   parameter  int                TICK_DIV       = DEF_TICK_DIV,
   parameter  int                BLANK_CYC      = DEF_BLANK_CYC,
   parameter  logic [DATA_W-1:0] BLANK_PAT      = '1,
   parameter  bit                SEL_ACTIVE_LOW = 1'b1,
   localparam int                DG_W           = $clog2(N_DIGITS)
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [N_DIGITS*DATA_W-1:0]   i_data,
   input  logic [N_DIGITS-1:0]          i_digit_en,
   input  logic                         i_load,
   output logic                         o_load_ack,
   output logic [DATA_W-1:0]            o_data,
   output logic [N_DIGITS-1:0]          o_sel,
   output logic [DG_W-1:0]              o_digit,
   output logic                         o_frame
);

   localparam int PH_W = $clog2(TICK_DIV);
   localparam logic [N_DIGITS-1:0] SEL_IDLE = N_DIGITS'(sel_idle(SEL_ACTIVE_LOW));

   logic [PH_W-1:0]              w_phase_unused;
   logic [DG_W-1:0]              w_digit;
   logic                         w_blank;
   logic                         w_frame_edge;
   logic                         w_capture;
   logic [N_DIGITS*DATA_W-1:0]   w_shd_data_nxt;
   logic [N_DIGITS-1:0]          w_shd_en_nxt;
   slot_state_e                  w_slot;
   logic [N_DIGITS-1:0]          w_sel_nxt;
   logic [DATA_W-1:0]            w_data_nxt;

   logic                         r_pending;
   logic [N_DIGITS*DATA_W-1:0]   r_shd_data;
   logic [N_DIGITS-1:0]          r_shd_en;
   logic                         r_load_ack;
   logic [DATA_W-1:0]            r_data;
   logic [N_DIGITS-1:0]          r_sel;
   logic [DG_W-1:0]              r_digit;
   logic                         r_frame;

   seg_scan_timer #(
      .N_DIGITS  (N_DIGITS),
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .o_phase      (w_phase_unused),
      .o_digit      (w_digit),
      .o_blank      (w_blank),
      .o_frame_edge (w_frame_edge)
   );

   // The output registers load from the post-capture shadow view, so the
   // first cycle of a frame already reflects freshly captured data (this
   // matters when BLANK_CYC = 0).
   always_comb begin
      w_capture      = w_frame_edge & (r_pending | i_load);
      w_shd_data_nxt = w_capture ? i_data     : r_shd_data;
      w_shd_en_nxt   = w_capture ? i_digit_en : r_shd_en;

      w_slot = (!w_blank && w_shd_en_nxt[w_digit]) ? SLOT_SHOW : SLOT_BLANK;

      w_sel_nxt  = SEL_IDLE;
      w_data_nxt = BLANK_PAT;
      if (w_slot == SLOT_SHOW) begin
         w_sel_nxt  = N_DIGITS'(sel_onehot(32'(w_digit), SEL_ACTIVE_LOW));
         w_data_nxt = w_shd_data_nxt[int'(w_digit)*DATA_W +: DATA_W];
      end
   end

   // Load bookkeeping and shadow registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pending  <= 1'b0;
         r_shd_data <= {N_DIGITS{BLANK_PAT}};
         r_shd_en   <= '0;
      end else begin
         if (w_capture) begin
            r_pending <= 1'b0;
         end else if (i_load) begin
            r_pending <= 1'b1;
         end
         r_shd_data <= w_shd_data_nxt;
         r_shd_en   <= w_shd_en_nxt;
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_load_ack <= 1'b0;
         r_data     <= BLANK_PAT;
         r_sel      <= SEL_IDLE;
         r_digit    <= '0;
         r_frame    <= 1'b0;
      end else begin
         r_load_ack <= w_capture;
         r_data     <= w_data_nxt;
         r_sel      <= w_sel_nxt;
         r_digit    <= w_digit;
         r_frame    <= w_frame_edge;
      end
   end

   assign o_load_ack = r_load_ack;
   assign o_data     = r_data;
   assign o_sel      = r_sel;
   assign o_digit    = r_digit;
   assign o_frame    = r_frame;

endmodule
